cgra_top: RTL and testbench

Top-level tile of a small coarse-grained reconfigurable array. It exposes four 16-track, 1-bit-per-track pad sides (S0..S3) as inputs and outputs. A memory-mapped configuration port routes input sides, or a single 16-bit ALU processing element (PE), onto registered output sides. JTAG pins are present for pin compatibility only and are inert.

---
 rtl/cgra_top_if.sv | 8 +
 rtl/cgra_top.sv | 162 ++++++++++++++++
 tb/tb_cgra_top.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_top_if.sv
// Configuration bus of the CGRA tile: an address/data pair sampled every edge.
interface cgra_top_if;
  logic [31:0] config_addr_in;
  logic [31:0] config_data_in;

  modport master (output config_addr_in, config_data_in);
  modport slave  (input  config_addr_in, config_data_in);
endinterface

// File: rtl/cgra_top.sv
// Single CGRA tile: four 16-track pad sides routed, directly or through one
// 16-bit ALU PE, onto registered output sides under memory-mapped config.
module cgra_top (
  input  logic clk_in,
  input  logic reset_in,
  cgra_top_if.slave i_cfg,
  input  logic pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in, pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
  input  logic pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in, pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
  input  logic pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in, pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
  input  logic pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in, pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
  input  logic pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in, pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
  input  logic pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in, pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in,
  input  logic pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in, pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
  input  logic pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in, pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in,
  output logic pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out, pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
  output logic pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out, pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out,
  output logic pad_S1_T0_out, pad_S1_T1_out, pad_S1_T2_out, pad_S1_T3_out, pad_S1_T4_out, pad_S1_T5_out, pad_S1_T6_out, pad_S1_T7_out,
  output logic pad_S1_T8_out, pad_S1_T9_out, pad_S1_T10_out, pad_S1_T11_out, pad_S1_T12_out, pad_S1_T13_out, pad_S1_T14_out, pad_S1_T15_out,
  output logic pad_S2_T0_out, pad_S2_T1_out, pad_S2_T2_out, pad_S2_T3_out, pad_S2_T4_out, pad_S2_T5_out, pad_S2_T6_out, pad_S2_T7_out,
  output logic pad_S2_T8_out, pad_S2_T9_out, pad_S2_T10_out, pad_S2_T11_out, pad_S2_T12_out, pad_S2_T13_out, pad_S2_T14_out, pad_S2_T15_out,
  output logic pad_S3_T0_out, pad_S3_T1_out, pad_S3_T2_out, pad_S3_T3_out, pad_S3_T4_out, pad_S3_T5_out, pad_S3_T6_out, pad_S3_T7_out,
  output logic pad_S3_T8_out, pad_S3_T9_out, pad_S3_T10_out, pad_S3_T11_out, pad_S3_T12_out, pad_S3_T13_out, pad_S3_T14_out, pad_S3_T15_out,
  input  logic tdi,
  input  logic tms,
  input  logic tck,
  input  logic trst_n,
  output logic tdo
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_PASS = 4'd8
  } pe_op_e;

  logic [2:0]  r_outsel [4];
  pe_op_e      r_pe_op;
  logic [2:0]  r_pe_asel;
  logic [2:0]  r_pe_bsel;
  logic [15:0] r_pe_const;
  logic [15:0] r_out [4];

  logic [15:0] w_side [4];
  logic [15:0] w_pe_a;
  logic [15:0] w_pe_b;
  logic [31:0] w_pe_prod;
  logic [15:0] w_pe_res;
  logic [15:0] w_out_nxt [4];
  logic        w_unused;

  // Side words: track T0 is the MSB.
  assign w_side[0] = {pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in, pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
                      pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in, pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
  assign w_side[1] = {pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in, pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
                      pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in, pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
  assign w_side[2] = {pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in, pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
                      pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in, pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
  assign w_side[3] = {pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in, pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
                      pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in, pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};

  assign {pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out, pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
          pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out, pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = r_out[0];
  assign {pad_S1_T0_out, pad_S1_T1_out, pad_S1_T2_out, pad_S1_T3_out, pad_S1_T4_out, pad_S1_T5_out, pad_S1_T6_out, pad_S1_T7_out,
          pad_S1_T8_out, pad_S1_T9_out, pad_S1_T10_out, pad_S1_T11_out, pad_S1_T12_out, pad_S1_T13_out, pad_S1_T14_out, pad_S1_T15_out} = r_out[1];
  assign {pad_S2_T0_out, pad_S2_T1_out, pad_S2_T2_out, pad_S2_T3_out, pad_S2_T4_out, pad_S2_T5_out, pad_S2_T6_out, pad_S2_T7_out,
          pad_S2_T8_out, pad_S2_T9_out, pad_S2_T10_out, pad_S2_T11_out, pad_S2_T12_out, pad_S2_T13_out, pad_S2_T14_out, pad_S2_T15_out} = r_out[2];
  assign {pad_S3_T0_out, pad_S3_T1_out, pad_S3_T2_out, pad_S3_T3_out, pad_S3_T4_out, pad_S3_T5_out, pad_S3_T6_out, pad_S3_T7_out,
          pad_S3_T8_out, pad_S3_T9_out, pad_S3_T10_out, pad_S3_T11_out, pad_S3_T12_out, pad_S3_T13_out, pad_S3_T14_out, pad_S3_T15_out} = r_out[3];

  // JTAG pins and discarded config data bits are inert; folding them into a
  // constant-zero tdo keeps them referenced without affecting behaviour.
  assign w_unused = ^{tdi, tms, tck, trst_n, i_cfg.config_data_in[31:16]};
  assign tdo      = w_unused & 1'b0;

  // PE operand source: 0 = constant, 1..4 = input side, others = zero.
  function automatic logic [15:0] f_operand(input logic [2:0] sel, input logic [15:0] cst,
                                            input logic [15:0] s0, input logic [15:0] s1,
                                            input logic [15:0] s2, input logic [15:0] s3);
    case (sel)
      3'd0:    return cst;
      3'd1:    return s0;
      3'd2:    return s1;
      3'd3:    return s2;
      3'd4:    return s3;
      default: return '0;
    endcase
  endfunction

  assign w_pe_a    = f_operand(r_pe_asel, r_pe_const, w_side[0], w_side[1], w_side[2], w_side[3]);
  assign w_pe_b    = f_operand(r_pe_bsel, r_pe_const, w_side[0], w_side[1], w_side[2], w_side[3]);
  assign w_pe_prod = {16'd0, w_pe_a} * {16'd0, w_pe_b};

  // Combinational ALU, all results wrap to 16 bits.
  always_comb begin
    w_pe_res = '0;
    case (r_pe_op)
      OP_ADD:  w_pe_res = w_pe_a + w_pe_b;
      OP_SUB:  w_pe_res = w_pe_a - w_pe_b;
      OP_MUL:  w_pe_res = w_pe_prod[15:0];
      OP_AND:  w_pe_res = w_pe_a & w_pe_b;
      OP_OR:   w_pe_res = w_pe_a | w_pe_b;
      OP_XOR:  w_pe_res = w_pe_a ^ w_pe_b;
      OP_SHL:  w_pe_res = w_pe_a << w_pe_b[3:0];
      OP_SHR:  w_pe_res = w_pe_a >> w_pe_b[3:0];
      OP_PASS: w_pe_res = w_pe_a;
      default: w_pe_res = '0;
    endcase
  end

  // Next value of each output register from its OUTSEL source.
  always_comb begin
    for (int unsigned s = 0; s < 4; s++) begin
      w_out_nxt[s] = '0;
      case (r_outsel[s])
        3'd1:    w_out_nxt[s] = w_side[0];
        3'd2:    w_out_nxt[s] = w_side[1];
        3'd3:    w_out_nxt[s] = w_side[2];
        3'd4:    w_out_nxt[s] = w_side[3];
        3'd5:    w_out_nxt[s] = w_pe_res;
        default: w_out_nxt[s] = '0;
      endcase
    end
  end

  // Configuration register file; reset overrides a coincident write.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int unsigned s = 0; s < 4; s++) r_outsel[s] <= '0;
      r_pe_op    <= OP_ADD;
      r_pe_asel  <= '0;
      r_pe_bsel  <= '0;
      r_pe_const <= '0;
    end else begin
      case (i_cfg.config_addr_in)
        32'h01: r_outsel[0] <= i_cfg.config_data_in[2:0];
        32'h02: r_outsel[1] <= i_cfg.config_data_in[2:0];
        32'h03: r_outsel[2] <= i_cfg.config_data_in[2:0];
        32'h04: r_outsel[3] <= i_cfg.config_data_in[2:0];
        32'h10: r_pe_op     <= pe_op_e'(i_cfg.config_data_in[3:0]);
        32'h11: r_pe_asel   <= i_cfg.config_data_in[2:0];
        32'h12: r_pe_bsel   <= i_cfg.config_data_in[2:0];
        32'h13: r_pe_const  <= i_cfg.config_data_in[15:0];
        default: ;
      endcase
    end
  end

  // Output side registers, selected with the config held before this edge.
  always_ff @(posedge clk_in) begin
    for (int unsigned s = 0; s < 4; s++) begin
      if (reset_in) r_out[s] <= '0;
      else          r_out[s] <= w_out_nxt[s];
    end
  end

endmodule

// File: tb/tb_cgra_top.sv
// Directed bench for cgra_top: routing, PE ops, latency, config timing, reset.
module tb_cgra_top;
  logic        clk;
  logic        rst;
  logic [15:0] s_in [4];
  wire  [15:0] s_out [4];
  logic        tdi, tms, tck, trst_n;
  wire         tdo;
  int          n_cmp;
  int          n_bad;

  cgra_top_if u_cfg ();

  cgra_top dut (
    .clk_in(clk), .reset_in(rst), .i_cfg(u_cfg),
    .pad_S0_T0_in(s_in[0][15]), .pad_S0_T1_in(s_in[0][14]), .pad_S0_T2_in(s_in[0][13]), .pad_S0_T3_in(s_in[0][12]),
    .pad_S0_T4_in(s_in[0][11]), .pad_S0_T5_in(s_in[0][10]), .pad_S0_T6_in(s_in[0][9]), .pad_S0_T7_in(s_in[0][8]),
    .pad_S0_T8_in(s_in[0][7]), .pad_S0_T9_in(s_in[0][6]), .pad_S0_T10_in(s_in[0][5]), .pad_S0_T11_in(s_in[0][4]),
    .pad_S0_T12_in(s_in[0][3]), .pad_S0_T13_in(s_in[0][2]), .pad_S0_T14_in(s_in[0][1]), .pad_S0_T15_in(s_in[0][0]),
    .pad_S1_T0_in(s_in[1][15]), .pad_S1_T1_in(s_in[1][14]), .pad_S1_T2_in(s_in[1][13]), .pad_S1_T3_in(s_in[1][12]),
    .pad_S1_T4_in(s_in[1][11]), .pad_S1_T5_in(s_in[1][10]), .pad_S1_T6_in(s_in[1][9]), .pad_S1_T7_in(s_in[1][8]),
    .pad_S1_T8_in(s_in[1][7]), .pad_S1_T9_in(s_in[1][6]), .pad_S1_T10_in(s_in[1][5]), .pad_S1_T11_in(s_in[1][4]),
    .pad_S1_T12_in(s_in[1][3]), .pad_S1_T13_in(s_in[1][2]), .pad_S1_T14_in(s_in[1][1]), .pad_S1_T15_in(s_in[1][0]),
    .pad_S2_T0_in(s_in[2][15]), .pad_S2_T1_in(s_in[2][14]), .pad_S2_T2_in(s_in[2][13]), .pad_S2_T3_in(s_in[2][12]),
    .pad_S2_T4_in(s_in[2][11]), .pad_S2_T5_in(s_in[2][10]), .pad_S2_T6_in(s_in[2][9]), .pad_S2_T7_in(s_in[2][8]),
    .pad_S2_T8_in(s_in[2][7]), .pad_S2_T9_in(s_in[2][6]), .pad_S2_T10_in(s_in[2][5]), .pad_S2_T11_in(s_in[2][4]),
    .pad_S2_T12_in(s_in[2][3]), .pad_S2_T13_in(s_in[2][2]), .pad_S2_T14_in(s_in[2][1]), .pad_S2_T15_in(s_in[2][0]),
    .pad_S3_T0_in(s_in[3][15]), .pad_S3_T1_in(s_in[3][14]), .pad_S3_T2_in(s_in[3][13]), .pad_S3_T3_in(s_in[3][12]),
    .pad_S3_T4_in(s_in[3][11]), .pad_S3_T5_in(s_in[3][10]), .pad_S3_T6_in(s_in[3][9]), .pad_S3_T7_in(s_in[3][8]),
    .pad_S3_T8_in(s_in[3][7]), .pad_S3_T9_in(s_in[3][6]), .pad_S3_T10_in(s_in[3][5]), .pad_S3_T11_in(s_in[3][4]),
    .pad_S3_T12_in(s_in[3][3]), .pad_S3_T13_in(s_in[3][2]), .pad_S3_T14_in(s_in[3][1]), .pad_S3_T15_in(s_in[3][0]),
    .pad_S0_T0_out(s_out[0][15]), .pad_S0_T1_out(s_out[0][14]), .pad_S0_T2_out(s_out[0][13]), .pad_S0_T3_out(s_out[0][12]),
    .pad_S0_T4_out(s_out[0][11]), .pad_S0_T5_out(s_out[0][10]), .pad_S0_T6_out(s_out[0][9]), .pad_S0_T7_out(s_out[0][8]),
    .pad_S0_T8_out(s_out[0][7]), .pad_S0_T9_out(s_out[0][6]), .pad_S0_T10_out(s_out[0][5]), .pad_S0_T11_out(s_out[0][4]),
    .pad_S0_T12_out(s_out[0][3]), .pad_S0_T13_out(s_out[0][2]), .pad_S0_T14_out(s_out[0][1]), .pad_S0_T15_out(s_out[0][0]),
    .pad_S1_T0_out(s_out[1][15]), .pad_S1_T1_out(s_out[1][14]), .pad_S1_T2_out(s_out[1][13]), .pad_S1_T3_out(s_out[1][12]),
    .pad_S1_T4_out(s_out[1][11]), .pad_S1_T5_out(s_out[1][10]), .pad_S1_T6_out(s_out[1][9]), .pad_S1_T7_out(s_out[1][8]),
    .pad_S1_T8_out(s_out[1][7]), .pad_S1_T9_out(s_out[1][6]), .pad_S1_T10_out(s_out[1][5]), .pad_S1_T11_out(s_out[1][4]),
    .pad_S1_T12_out(s_out[1][3]), .pad_S1_T13_out(s_out[1][2]), .pad_S1_T14_out(s_out[1][1]), .pad_S1_T15_out(s_out[1][0]),
    .pad_S2_T0_out(s_out[2][15]), .pad_S2_T1_out(s_out[2][14]), .pad_S2_T2_out(s_out[2][13]), .pad_S2_T3_out(s_out[2][12]),
    .pad_S2_T4_out(s_out[2][11]), .pad_S2_T5_out(s_out[2][10]), .pad_S2_T6_out(s_out[2][9]), .pad_S2_T7_out(s_out[2][8]),
    .pad_S2_T8_out(s_out[2][7]), .pad_S2_T9_out(s_out[2][6]), .pad_S2_T10_out(s_out[2][5]), .pad_S2_T11_out(s_out[2][4]),
    .pad_S2_T12_out(s_out[2][3]), .pad_S2_T13_out(s_out[2][2]), .pad_S2_T14_out(s_out[2][1]), .pad_S2_T15_out(s_out[2][0]),
    .pad_S3_T0_out(s_out[3][15]), .pad_S3_T1_out(s_out[3][14]), .pad_S3_T2_out(s_out[3][13]), .pad_S3_T3_out(s_out[3][12]),
    .pad_S3_T4_out(s_out[3][11]), .pad_S3_T5_out(s_out[3][10]), .pad_S3_T6_out(s_out[3][9]), .pad_S3_T7_out(s_out[3][8]),
    .pad_S3_T8_out(s_out[3][7]), .pad_S3_T9_out(s_out[3][6]), .pad_S3_T10_out(s_out[3][5]), .pad_S3_T11_out(s_out[3][4]),
    .pad_S3_T12_out(s_out[3][3]), .pad_S3_T13_out(s_out[3][2]), .pad_S3_T14_out(s_out[3][1]), .pad_S3_T15_out(s_out[3][0]),
    .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a config write for exactly one edge.
  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    u_cfg.config_addr_in = addr;
    u_cfg.config_data_in = data;
    tick();
    u_cfg.config_addr_in = '0;
    u_cfg.config_data_in = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    s_in[0] = 16'hFFFF; s_in[1] = 16'h1357; s_in[2] = 16'h2468; s_in[3] = 16'h8001;
    tdi = 1'b1; tms = 1'b1; tck = 1'b1; trst_n = 1'b0;
    cfg_write(32'h01, 32'h1);
    cfg_write(32'h02, 32'h2);
    tick();
    rst = 1'b1;
    u_cfg.config_addr_in = 32'h03;
    u_cfg.config_data_in = 32'h4;
    tick();
    rst = 1'b0;
    u_cfg.config_addr_in = '0;
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (s_out[s] !== 16'h0000) begin
        n_bad++;
        $display("FAIL reset_side%0d: got %h want 0000", s, s_out[s]);
      end
    end
    n_cmp++;
    if (tdo !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tdo: got %b want 0", tdo);
    end
    cfg_write(32'h00, 32'h1);
    cfg_write(32'h05, 32'h1);
    cfg_write(32'h101, 32'h1);
    cfg_write(32'h14, 32'h1);
    tick();
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (s_out[s] !== 16'h0000) begin
        n_bad++;
        $display("FAIL unmapped_side%0d: got %h want 0000", s, s_out[s]);
      end
    end
  endtask

  task automatic test_passthrough();
    s_in[0] = 16'h5A5A; s_in[2] = 16'h0003;
    cfg_write(32'h03, 32'h1);
    cfg_write(32'h01, 32'h3);
    n_cmp++;
    if (s_out[0] !== 16'h0000) begin
      n_bad++;
      $display("FAIL pass_not_yet: got %h want 0000", s_out[0]);
    end
    n_cmp++;
    if (s_out[2] !== 16'h5A5A) begin
      n_bad++;
      $display("FAIL pass_side2: got %h want 5a5a", s_out[2]);
    end
    tick();
    n_cmp++;
    if (s_out[0] !== 16'h0003) begin
      n_bad++;
      $display("FAIL pass_side0: got %h want 0003", s_out[0]);
    end
    n_cmp++;
    if ({dut.pad_S0_T15_out, dut.pad_S0_T14_out, dut.pad_S0_T0_out} !== 3'b110) begin
      n_bad++;
      $display("FAIL pass_pads: got %b want 110", {dut.pad_S0_T15_out, dut.pad_S0_T14_out, dut.pad_S0_T0_out});
    end
  endtask

  task automatic test_pe_double();
    s_in[2] = 16'h0003;
    cfg_write(32'h11, 32'h3);
    cfg_write(32'h12, 32'h3);
    cfg_write(32'h10, 32'h0);
    cfg_write(32'h01, 32'h5);
    tick();
    n_cmp++;
    if (s_out[0] !== 16'h0006) begin
      n_bad++;
      $display("FAIL pe_add: got %h want 0006", s_out[0]);
    end
    cfg_write(32'h10, 32'h2);
    n_cmp++;
    if (s_out[0] !== 16'h0006) begin
      n_bad++;
      $display("FAIL pe_mul_early: got %h want 0006", s_out[0]);
    end
    tick();
    n_cmp++;
    if (s_out[0] !== 16'h0009) begin
      n_bad++;
      $display("FAIL pe_mul: got %h want 0009", s_out[0]);
    end
  endtask

  task automatic test_pe_const();
    logic [3:0]  ops [9];
    logic [15:0] exp [9];
    ops = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};
    // A = 0xFFFF, B = 3
    exp = '{16'h0002, 16'hFFFC, 16'hFFF8, 16'h1FFF, 16'h0003, 16'hFFFF, 16'hFFFC, 16'hFFFF, 16'h0000};
    s_in[2] = 16'h0003;
    cfg_write(32'h13, 32'hABCD_FFFF);
    cfg_write(32'h11, 32'h0);
    cfg_write(32'h12, 32'h3);
    for (int i = 0; i < 9; i++) begin
      cfg_write(32'h10, {28'h0, ops[i]});
      tick();
      n_cmp++;
      if (s_out[0] !== exp[i]) begin
        n_bad++;
        $display("FAIL pe_const_op%0d: got %h want %h", ops[i], s_out[0], exp[i]);
      end
    end
  endtask

  task automatic test_latency();
    s_in[0] = 16'h1234;
    cfg_write(32'h02, 32'h1);
    tick();
    n_cmp++;
    if (s_out[1] !== 16'h1234) begin
      n_bad++;
      $display("FAIL lat_first: got %h want 1234", s_out[1]);
    end
    s_in[0] = 16'hABCD;
    #2;
    n_cmp++;
    if (s_out[1] !== 16'h1234) begin
      n_bad++;
      $display("FAIL lat_hold: got %h want 1234", s_out[1]);
    end
    tick();
    n_cmp++;
    if (s_out[1] !== 16'hABCD) begin
      n_bad++;
      $display("FAIL lat_next: got %h want abcd", s_out[1]);
    end
  endtask

  task automatic test_back_to_back();
    s_in[0] = 16'h0F0F; s_in[1] = 16'hC3C3; s_in[3] = 16'h7E7E;
    cfg_write(32'h04, 32'h1);
    cfg_write(32'h04, 32'h2);
    tick();
    n_cmp++;
    if (s_out[3] !== 16'hC3C3) begin
      n_bad++;
      $display("FAIL b2b_last: got %h want c3c3", s_out[3]);
    end
    cfg_write(32'h04, 32'hFFFF_FFFC);
    tick();
    n_cmp++;
    if (s_out[3] !== 16'h7E7E) begin
      n_bad++;
      $display("FAIL upper_bits: got %h want 7e7e", s_out[3]);
    end
    cfg_write(32'h04, 32'h6);
    tick();
    n_cmp++;
    if (s_out[3] !== 16'h0000) begin
      n_bad++;
      $display("FAIL outsel6: got %h want 0000", s_out[3]);
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(32'h03, 32'h2);
    s_in[1] = 16'h4444;
    tick();
    n_cmp++;
    if (s_out[2] !== 16'h4444) begin
      n_bad++;
      $display("FAIL mid_pre: got %h want 4444", s_out[2]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_in[0] = 16'h1111 * (k + 1);
      s_in[1] = 16'h2222 * (k + 1);
      s_in[2] = 16'h0101 * (k + 1);
      tick();
      for (int s = 0; s < 4; s++) begin
        n_cmp++;
        if (s_out[s] !== 16'h0000) begin
          n_bad++;
          $display("FAIL mid_zero_side%0d: got %h want 0000", s, s_out[s]);
        end
      end
    end
    s_in[1] = 16'h9876;
    cfg_write(32'h01, 32'h2);
    tick();
    n_cmp++;
    if (s_out[0] !== 16'h9876) begin
      n_bad++;
      $display("FAIL mid_reconf: got %h want 9876", s_out[0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    u_cfg.config_addr_in = '0;
    u_cfg.config_data_in = '0;
    for (int s = 0; s < 4; s++) s_in[s] = '0;
    tdi = 1'b0; tms = 1'b0; tck = 1'b0; trst_n = 1'b1;
    tick();
    rst = 1'b0;
    test_reset();
    test_passthrough();
    test_pe_double();
    test_pe_const();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
